// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle accumulator CPU: states, opcodes,
// Func bit indices, ALU codes and datapath mux select codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEM_RD = 4'd2,
        S_WB_MEM = 4'd3,
        S_MEM_WR = 4'd4,
        S_JMP    = 4'd5,
        S_BRZ    = 4'd6,
        S_EXEC_R = 4'd7,
        S_EXEC_I = 4'd8,
        S_WB_ALU = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        CL_LOAD, CL_STORE, CL_JUMP, CL_BRZ, CL_TYPEC, CL_IMM, CL_UNDEF
    } op_class_t;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_JUMP  = 4'b0010;
    localparam logic [3:0] OP_BRZ   = 4'b0100;
    localparam logic [3:0] OP_TYPEC = 4'b1000;
    localparam logic [3:0] OP_ADDI  = 4'b1100;
    localparam logic [3:0] OP_SUBI  = 4'b1101;
    localparam logic [3:0] OP_ANDI  = 4'b1110;
    localparam logic [3:0] OP_ORI   = 4'b1111;

    localparam int F_MOVETO   = 0;
    localparam int F_MOVEFROM = 1;
    localparam int F_ADD      = 2;
    localparam int F_SUB      = 3;
    localparam int F_AND      = 4;
    localparam int F_OR       = 5;
    localparam int F_NOT      = 6;
    localparam int F_NOP      = 7;
    localparam int F_RSVD     = 8;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_NOT   = 3'b100;
    localparam logic [2:0] ALU_PASSA = 3'b101;
    localparam logic [2:0] ALU_PASSB = 3'b110;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_REGA = 2'b10;
    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] PCSRC_ALU = 2'b00;
    localparam logic [1:0] PCSRC_JMP = 2'b01;
    localparam logic [1:0] PCSRC_BR  = 2'b10;
    localparam logic [1:0] IMM_SEXT12 = 2'b00;

    function automatic op_class_t classify(input logic [3:0] op);
        case (op)
            OP_LOAD:  return CL_LOAD;
            OP_STORE: return CL_STORE;
            OP_JUMP:  return CL_JUMP;
            OP_BRZ:   return CL_BRZ;
            OP_TYPEC: return CL_TYPEC;
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: return CL_IMM;
            default:  return CL_UNDEF;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decode: (op class, Func / Op[1:0]) -> ALUControl plus
// MOVETO, NOP and illegal-instruction flags.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  op_class_t   op_class,
    input  logic [8:0]  func,
    input  logic [1:0]  op_lo,
    output logic [2:0]  alu_control,
    output logic        moveto,
    output logic        nop,
    output logic        illegal
);
    logic func_ok;
    logic is_typec;

    assign func_ok  = $onehot(func) && !func[F_RSVD];
    assign is_typec = (op_class == CL_TYPEC);
    assign moveto   = is_typec && func_ok && func[F_MOVETO];
    assign nop      = is_typec && func_ok && func[F_NOP];
    assign illegal  = (op_class == CL_UNDEF) || (is_typec && !func_ok);

    always_comb begin
        alu_control = ALU_ADD;
        if (op_class == CL_IMM) begin
            // Immediate opcodes encode ADD/SUB/AND/OR directly in Op[1:0].
            alu_control = {1'b0, op_lo};
        end else if (is_typec) begin
            if (func[F_MOVETO])        alu_control = ALU_PASSA;
            else if (func[F_MOVEFROM]) alu_control = ALU_PASSB;
            else if (func[F_SUB])      alu_control = ALU_SUB;
            else if (func[F_AND])      alu_control = ALU_AND;
            else if (func[F_OR])       alu_control = ALU_OR;
            else if (func[F_NOT])      alu_control = ALU_NOT;
            else                       alu_control = ALU_ADD;
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle controller FSM for the 16-bit accumulator CPU.
// Optional macro MC_ILLEGAL_HALT_EN: undefined instructions halt and set illegal.
module mc_control_unit
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         Op,
    input  logic [8:0]         Func,
    input  logic               Zero,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [2:0]         ALUControl,
    output logic               A3Src,
    output logic               PCWrite,
    output logic               OldPCWrite,
    output logic               MDRWrite,
    output logic               ResultSrc,
    output logic               AWrite,
    output logic               BWrite,
    output logic [1:0]         PCSrc,
    output logic               illegal,
    output logic [STATE_W-1:0] dbg_state
);
    state_t     state_reg;
    op_class_t  op_class;
    op_class_t  cls_reg;
    logic [2:0] alu_ctl_reg;
    logic       moveto_reg;
    logic [2:0] dec_alu;
    logic       dec_moveto, dec_nop, dec_illegal;

    assign op_class  = classify(Op);
    assign dbg_state = STATE_W'(state_reg);

    mc_alu_decoder u_alu_dec (
        .op_class    (op_class),
        .func        (Func),
        .op_lo       (Op[1:0]),
        .alu_control (dec_alu),
        .moveto      (dec_moveto),
        .nop         (dec_nop),
        .illegal     (dec_illegal)
    );

`ifdef MC_ILLEGAL_HALT_EN
    logic illegal_reg;
    assign illegal = illegal_reg;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_FETCH;
            cls_reg     <= CL_UNDEF;
            alu_ctl_reg <= ALU_ADD;
            moveto_reg  <= 1'b0;
`ifdef MC_ILLEGAL_HALT_EN
            illegal_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_FETCH:  state_reg <= S_DECODE;
                S_DECODE: begin
                    // Later states use only this snapshot, not the live Op/Func.
                    cls_reg     <= op_class;
                    alu_ctl_reg <= dec_alu;
                    moveto_reg  <= dec_moveto;
                    if (dec_illegal) begin
`ifdef MC_ILLEGAL_HALT_EN
                        state_reg   <= S_HALT;
                        illegal_reg <= 1'b1;
`else
                        state_reg   <= S_FETCH;
`endif
                    end else begin
                        case (op_class)
                            CL_LOAD:  state_reg <= S_MEM_RD;
                            CL_STORE: state_reg <= S_MEM_WR;
                            CL_JUMP:  state_reg <= S_JMP;
                            CL_BRZ:   state_reg <= S_BRZ;
                            CL_TYPEC: state_reg <= dec_nop ? S_FETCH : S_EXEC_R;
                            CL_IMM:   state_reg <= S_EXEC_I;
                            default:  state_reg <= S_FETCH;
                        endcase
                    end
                end
                S_MEM_RD: state_reg <= S_WB_MEM;
                S_EXEC_R, S_EXEC_I: state_reg <= S_WB_ALU;
`ifdef MC_ILLEGAL_HALT_EN
                S_HALT:   state_reg <= S_HALT;
`endif
                default:  state_reg <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        AdrSrc = 1'b0;  MemWrite = 1'b0;  IRWrite = 1'b0;  RegWrite = 1'b0;
        ALUSrcA = 2'b00; ALUSrcB = 2'b00; ImmSrc = 2'b00; ALUControl = ALU_ADD;
        A3Src = 1'b0;   PCWrite = 1'b0;   OldPCWrite = 1'b0; MDRWrite = 1'b0;
        ResultSrc = 1'b0; AWrite = 1'b0;  BWrite = 1'b0;  PCSrc = 2'b00;
        case (state_reg)
            S_FETCH: begin
                IRWrite = 1'b1; OldPCWrite = 1'b1; PCWrite = 1'b1;
                ALUSrcA = SRCA_PC; ALUSrcB = SRCB_ONE; PCSrc = PCSRC_ALU;
            end
            S_DECODE: begin
                AWrite = 1'b1; BWrite = 1'b1;
            end
            S_MEM_RD: begin
                AdrSrc = 1'b1; MDRWrite = 1'b1;
            end
            S_WB_MEM: begin
                ResultSrc = 1'b1; RegWrite = 1'b1;
            end
            S_MEM_WR: begin
                AdrSrc = 1'b1; MemWrite = 1'b1;
            end
            S_JMP: begin
                PCSrc = PCSRC_JMP; PCWrite = 1'b1;
            end
            S_BRZ: begin
                ALUSrcA = SRCA_REGA; ALUControl = ALU_PASSA;
                PCSrc = PCSRC_BR; PCWrite = Zero;
            end
            S_EXEC_R: begin
                ALUSrcA = SRCA_REGA; ALUSrcB = SRCB_REGB; ALUControl = alu_ctl_reg;
            end
            S_EXEC_I: begin
                ALUSrcA = SRCA_REGA; ALUSrcB = SRCB_IMM; ImmSrc = IMM_SEXT12;
                ALUControl = alu_ctl_reg;
            end
            S_WB_ALU: begin
                RegWrite = 1'b1;
                A3Src = moveto_reg && (cls_reg == CL_TYPEC);
            end
            default: ;
        endcase
        // Strobes must drop the instant reset asserts, even though FETCH is active.
        if (!reset) begin
            PCWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0; MemWrite = 1'b0;
            MDRWrite = 1'b0; OldPCWrite = 1'b0; AWrite = 1'b0; BWrite = 1'b0;
        end
    end

endmodule
